scratchpad_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of one `sram_1R1W` scratchpad between two requesters, for example the input pipeline and the output pipeline. Each requester gets bounded bursts of back-to-back writes through a req/gnt handshake. Requesters switch with no bubble cycle. The memory-side write port (`WE`, `WriteAddress`, `WriteBus`) is fully registered and connects directly to the SRAM.

---
 rtl/scratchpad_write_arbiter.sv | 111 +++++++++++
 tb/tb_scratchpad_write_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_write_arbiter.sv
// Round-robin arbiter that shares one SRAM write port between two requesters.
// Grants are bounded bursts with bubble-free handover; the SRAM-side port is fully registered.
module scratchpad_write_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              WE,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [DATA_W-1:0] WriteBus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              cur_req;
  logic              oth_req;
  logic              beat;
  logic [7:0]        cnt_inc;

  always_comb begin
    cur_req = (state_q == GRANT0) ? req0 : req1;
    oth_req = (state_q == GRANT0) ? req1 : req0;
    beat    = (state_q != IDLE) && cur_req;
    cnt_inc = cnt_q + 8'd1;

    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (req0 && (!req1 || !rr_q)) begin
          state_d = GRANT0;
        end else if (req1) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (beat) begin
          we_d    = 1'b1;
          waddr_d = (state_q == GRANT0) ? addr0 : addr1;
          wdata_d = (state_q == GRANT0) ? data0 : data1;
          cnt_d   = cnt_inc;
        end
        // Release on a dropped request or on the beat that exhausts the burst.
        if (!cur_req || (cnt_inc == BURST_LIMIT)) begin
          cnt_d = 8'd0;
          rr_d  = (state_q == GRANT0);
          if (oth_req) begin
            state_d = (state_q == GRANT0) ? GRANT1 : GRANT0;
          end else if (cur_req) begin
            state_d = state_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign gnt0         = (state_q == GRANT0);
  assign gnt1         = (state_q == GRANT1);
  assign WE           = we_q;
  assign WriteAddress = waddr_q;
  assign WriteBus     = wdata_q;

endmodule

// File: tb/tb_scratchpad_write_arbiter.sv
// Self-checking bench for scratchpad_write_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against an owner/tenure reference model.
module tb_scratchpad_write_arbiter;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 12;
  localparam int MAX_BURST = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              gnt0, gnt1, WE;
  logic [ADDR_W-1:0] WriteAddress;
  logic [DATA_W-1:0] WriteBus;

  scratchpad_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .WE(WE), .WriteAddress(WriteAddress), .WriteBus(WriteBus)
  );

  always #5 clock = ~clock;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: who owns the port, beats taken in this tenure, who is favoured next.
  int                owner = -1;
  int                taken = 0;
  int                fav   = 0;
  logic              mBeat0 = 1'b0;
  logic              mBeat1 = 1'b0;
  logic              expWe = 1'b0;
  logic [ADDR_W-1:0] expAddr = '0;
  logic [DATA_W-1:0] expData = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic r0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                               input logic r1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    reset = rst;
    req0 = r0; addr0 = a0; data0 = d0;
    req1 = r1; addr1 = a1; data1 = d1;
  endtask

  task automatic modelEdge();
    int me;
    logic myReq, otherReq;
    if (reset) begin
      owner = -1; taken = 0; fav = 0;
      mBeat0 = 1'b0; mBeat1 = 1'b0;
      expWe = 1'b0; expAddr = '0; expData = '0;
      return;
    end
    mBeat0 = (owner == 0) && req0;
    mBeat1 = (owner == 1) && req1;
    expWe  = mBeat0 || mBeat1;
    if (mBeat0) begin expAddr = addr0; expData = data0; taken++; end
    if (mBeat1) begin expAddr = addr1; expData = data1; taken++; end
    if (owner == -1) begin
      taken = 0;
      if (req0 && req1) owner = fav;
      else if (req0)    owner = 0;
      else if (req1)    owner = 1;
    end else begin
      me       = owner;
      myReq    = (me == 0) ? req0 : req1;
      otherReq = (me == 0) ? req1 : req0;
      if (!myReq || taken >= MAX_BURST) begin
        fav   = 1 - me;
        taken = 0;
        if (otherReq)   owner = 1 - me;
        else if (myReq) owner = me;
        else            owner = -1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    checkOutput("gnt0", 32'(gnt0), 32'(owner == 0));
    checkOutput("gnt1", 32'(gnt1), 32'(owner == 1));
    checkOutput("WE", 32'(WE), 32'(expWe));
    checkOutput("WriteAddress", 32'(WriteAddress), 32'(expAddr));
    checkOutput("WriteBus", 32'(WriteBus), 32'(expData));
  endtask

  task automatic resetCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                    1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      tick();
    end
  endtask

  initial begin
    int n0, n1, weLow;
    logic cr0, cr1, rst;
    logic [ADDR_W-1:0] ca0, ca1;
    logic [DATA_W-1:0] cd0, cd1;

    $display("[TB] reset");
    resetCycles(2);

    $display("[TB] single requester");
    n0 = 0;
    for (int c = 0; c < 20 && n0 < 6; c++) begin
      applyStimulus(1'b0, 1'b1, ADDR_W'(5 + n0), DATA_W'(16'hA005 + n0), 1'b0, '0, '0);
      tick();
      if (mBeat0) n0++;
      if (n0 < 6) checkOutput("singleGnt0Held", 32'(gnt0), 32'(1));
    end
    checkOutput("singleBeats", 32'(n0), 32'(6));
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    tick();

    $display("[TB] both requesting");
    resetCycles(1);
    n0 = 0; n1 = 0; weLow = 0;
    for (int c = 0; c < 30 && (n0 + n1) < 12; c++) begin
      applyStimulus(1'b0, 1'b1, ADDR_W'(12'h100 + n0), DATA_W'(16'hB000 + n0),
                    1'b1, ADDR_W'(12'h200 + n1), DATA_W'(16'hC000 + n1));
      tick();
      if (mBeat0) n0++;
      if (mBeat1) n1++;
      if ((n0 + n1) > 0 && WE !== 1'b1) weLow++;
    end
    checkOutput("bothBeats0", 32'(n0), 32'(8));
    checkOutput("bothBeats1", 32'(n1), 32'(4));
    checkOutput("bothWeGaps", 32'(weLow), 32'(0));

    $display("[TB] early drop");
    resetCycles(1);
    n0 = 0;
    for (int c = 0; c < 10 && n0 < 2; c++) begin
      applyStimulus(1'b0, 1'b1, ADDR_W'(12'h300 + n0), DATA_W'(16'hD000 + n0),
                    1'b1, 12'h400, 16'hE000);
      tick();
      if (mBeat0) n0++;
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 12'h400, 16'hE000);
    tick();
    checkOutput("earlyDropGnt0", 32'(gnt0), 32'(0));
    checkOutput("earlyDropGnt1", 32'(gnt1), 32'(1));
    checkOutput("earlyDropWeLow", 32'(WE), 32'(0));
    n1 = 0;
    for (int c = 0; c < 12 && n1 < 4; c++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(12'h400 + n1), DATA_W'(16'hE000 + n1));
      tick();
      if (mBeat1) n1++;
      if (n1 == 1 && mBeat1) checkOutput("earlyDropResume", 32'(WE), 32'(1));
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    applyStimulus(1'b0, 1'b1, 12'h310, 16'h1111, 1'b1, 12'h410, 16'h2222);
    tick();
    checkOutput("earlyDropRrBack0", 32'(gnt0), 32'(1));

    $display("[TB] pointer from idle");
    resetCycles(1);
    n0 = 0;
    for (int c = 0; c < 12 && n0 < 4; c++) begin
      applyStimulus(1'b0, 1'b1, ADDR_W'(12'h500 + n0), DATA_W'(16'h5000 + n0), 1'b0, '0, '0);
      tick();
      if (mBeat0) n0++;
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 12'h510, 16'h5100, 1'b1, 12'h610, 16'h6100);
    tick();
    checkOutput("pointerGnt1", 32'(gnt1), 32'(1));
    checkOutput("pointerGnt0", 32'(gnt0), 32'(0));

    $display("[TB] reset mid-burst");
    resetCycles(1);
    n1 = 0;
    for (int c = 0; c < 10 && n1 < 1; c++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(12'h700 + n1), DATA_W'(16'h7000 + n1));
      tick();
      if (mBeat1) n1++;
    end
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 12'h701, 16'h7001);
    tick();
    checkOutput("midResetWe", 32'(WE), 32'(0));
    checkOutput("midResetGnt1", 32'(gnt1), 32'(0));
    applyStimulus(1'b0, 1'b1, 12'h800, 16'h8000, 1'b1, 12'h702, 16'h7002);
    tick();
    checkOutput("midResetGnt0First", 32'(gnt0), 32'(1));

    $display("[TB] random traffic");
    cr0 = 1'b0; cr1 = 1'b0; ca0 = '0; ca1 = '0; cd0 = '0; cd1 = '0;
    for (int c = 0; c < 3000; c++) begin
      if (cr0 && !mBeat0) begin
        if ($urandom_range(7) == 0) cr0 = 1'b0;
      end else begin
        cr0 = ($urandom_range(3) != 0);
        ca0 = ADDR_W'($urandom);
        cd0 = DATA_W'($urandom);
      end
      if (cr1 && !mBeat1) begin
        if ($urandom_range(7) == 0) cr1 = 1'b0;
      end else begin
        cr1 = ($urandom_range(3) != 0);
        ca1 = ADDR_W'($urandom);
        cd1 = DATA_W'($urandom);
      end
      rst = ($urandom_range(199) == 0);
      applyStimulus(rst, cr0, ca0, cd0, cr1, ca1, cd1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
